// File: rtl/byte_decode_gearbox.sv
// Kyber ByteDecode_l unpacker: packed IN_W-bit beats in, LANES coefficients of COEF_W bits out,
// joined by a bit-buffer gearbox with valid/ready handshakes on both sides.
module byte_decode_gearbox #(
    parameter int IN_W   = 64,
    parameter int LANES  = 4,
    parameter int COEF_W = 12,
    parameter int N      = 256,
    parameter int Q      = 3329
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic                    i_start,
    input  logic [3:0]              i_l,
    input  logic [IN_W-1:0]         i_ibytes,
    input  logic                    i_ibytes_valid,
    output logic                    o_ibytes_ready,
    output logic [LANES*COEF_W-1:0] o_coeffs,
    output logic                    o_coeffs_valid,
    input  logic                    i_coeffs_ready,
    output logic                    o_done,
    output logic                    o_err
);
    localparam int BUF_W     = IN_W + LANES * COEF_W;
    localparam int CNT_W     = $clog2(BUF_W + 1);
    localparam int MAX_BEATS = N * 12 / IN_W;
    localparam int BEAT_W    = $clog2(MAX_BEATS + 1);
    localparam int OUT_BEATS = N / LANES;
    localparam int OUT_W     = $clog2(OUT_BEATS + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                    state;
    logic [3:0]                l_reg;
    logic [BUF_W-1:0]          buffer;
    logic [CNT_W-1:0]          cnt;
    logic [BEAT_W-1:0]         beats_left;
    logic [OUT_W-1:0]          out_cnt;

    logic [CNT_W-1:0]          chunk;
    logic                      legal_l;
    logic                      acc;
    logic                      out_free;
    logic                      ext;
    logic                      last_accept;
    logic [COEF_W-1:0]         field_mask;
    logic [COEF_W-1:0]         raw;
    logic [LANES*COEF_W-1:0]   fields;
    logic [BUF_W-1:0]          kept;
    logic [CNT_W-1:0]          kept_cnt;
    logic [BUF_W-1:0]          buf_next;
    logic [CNT_W-1:0]          cnt_next;

    assign chunk    = CNT_W'(LANES * int'(l_reg));
    assign legal_l  = (i_l == 4'd1) || (i_l == 4'd4) || (i_l == 4'd5) ||
                      (i_l == 4'd10) || (i_l == 4'd11) || (i_l == 4'd12);

    // A new beat is only taken when it is guaranteed to fit above the current fill level.
    assign o_ibytes_ready = (state == RUN) && (beats_left != '0) &&
                            (int'(cnt) + IN_W <= BUF_W);
    assign acc         = o_ibytes_ready && i_ibytes_valid;
    assign out_free    = !o_coeffs_valid || i_coeffs_ready;
    assign ext         = (state == RUN) && (cnt >= chunk) && out_free;
    assign last_accept = (state == RUN) && o_coeffs_valid && i_coeffs_ready &&
                         (out_cnt == OUT_W'(OUT_BEATS - 1));

    // Slice LANES fields off the buffer bottom; l=12 fields get one conditional subtraction of Q.
    always_comb begin
        fields     = '0;
        raw        = '0;
        field_mask = COEF_W'((1 << l_reg) - 1);
        for (int m = 0; m < LANES; m++) begin
            raw = COEF_W'(buffer >> (m * int'(l_reg))) & field_mask;
            if ((l_reg == 4'd12) && (raw >= COEF_W'(Q))) begin
                raw = raw - COEF_W'(Q);
            end
            fields[m*COEF_W +: COEF_W] = raw;
        end
    end

    // Extraction consumes from the bottom first, then the accepted beat lands above what remains.
    always_comb begin
        kept     = buffer;
        kept_cnt = cnt;
        if (ext) begin
            kept     = buffer >> chunk;
            kept_cnt = cnt - chunk;
        end
        buf_next = kept;
        cnt_next = kept_cnt;
        if (acc) begin
            buf_next = kept | (BUF_W'(i_ibytes) << kept_cnt);
            cnt_next = kept_cnt + CNT_W'(IN_W);
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state          <= IDLE;
            l_reg          <= '0;
            buffer         <= '0;
            cnt            <= '0;
            beats_left     <= '0;
            out_cnt        <= '0;
            o_coeffs       <= '0;
            o_coeffs_valid <= 1'b0;
            o_done         <= 1'b0;
            o_err          <= 1'b0;
        end else begin
            o_err  <= 1'b0;
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        if (legal_l) begin
                            l_reg          <= i_l;
                            buffer         <= '0;
                            cnt            <= '0;
                            beats_left     <= BEAT_W'(N * int'(i_l) / IN_W);
                            out_cnt        <= '0;
                            o_coeffs       <= '0;
                            o_coeffs_valid <= 1'b0;
                            state          <= RUN;
                        end else begin
                            o_err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    buffer <= buf_next;
                    cnt    <= cnt_next;
                    if (acc) begin
                        beats_left <= beats_left - BEAT_W'(1);
                    end
                    if (ext) begin
                        o_coeffs       <= fields;
                        o_coeffs_valid <= 1'b1;
                    end else if (i_coeffs_ready) begin
                        o_coeffs_valid <= 1'b0;
                    end
                    if (o_coeffs_valid && i_coeffs_ready) begin
                        out_cnt <= out_cnt + OUT_W'(1);
                    end
                    if (last_accept) begin
                        state  <= DONE;
                        o_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The stream length is a whole number of beats, so nothing may be left over at the end.
    assert property (@(posedge i_clk) disable iff (!i_rstn)
                     (state == DONE) |-> ((cnt == '0) && (beats_left == '0)));

endmodule

// File: tb/tb_byte_decode_gearbox.sv
// Bench for byte_decode_gearbox: random fields packed by an arithmetic bit-stream model,
// output beats compared against the expected coefficient list.
module tb_byte_decode_gearbox;
    localparam int IN_W      = 64;
    localparam int LANES     = 4;
    localparam int COEF_W    = 12;
    localparam int N         = 256;
    localparam int Q         = 3329;
    localparam int OUT_BEATS = N / LANES;

    logic                    i_clk = 1'b0;
    logic                    i_rstn = 1'b0;
    logic                    i_start = 1'b0;
    logic [3:0]              i_l = '0;
    logic [IN_W-1:0]         i_ibytes = '0;
    logic                    i_ibytes_valid = 1'b0;
    logic                    o_ibytes_ready;
    logic [LANES*COEF_W-1:0] o_coeffs;
    logic                    o_coeffs_valid;
    logic                    i_coeffs_ready = 1'b0;
    logic                    o_done;
    logic                    o_err;

    always #5 i_clk = ~i_clk;

    byte_decode_gearbox #(
        .IN_W(IN_W), .LANES(LANES), .COEF_W(COEF_W), .N(N), .Q(Q)
    ) dut (
        .i_clk(i_clk),
        .i_rstn(i_rstn),
        .i_start(i_start),
        .i_l(i_l),
        .i_ibytes(i_ibytes),
        .i_ibytes_valid(i_ibytes_valid),
        .o_ibytes_ready(o_ibytes_ready),
        .o_coeffs(o_coeffs),
        .o_coeffs_valid(o_coeffs_valid),
        .i_coeffs_ready(i_coeffs_ready),
        .o_done(o_done),
        .o_err(o_err)
    );

    int              compared = 0;
    int              mismatched = 0;
    int              done_pulses = 0;
    int              vals[N];
    int              exp_coef[N];
    logic [IN_W-1:0] beats[$];
    bit              abort_flag = 1'b0;

    always @(negedge i_clk) if (o_done === 1'b1) done_pulses++;

    task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: serialise every field LSB first into one bit list, cut it into beats.
    task automatic buildStream(input int l);
        bit bits[$];
        logic [IN_W-1:0] w;
        beats.delete();
        for (int j = 0; j < N; j++) begin
            for (int t = 0; t < l; t++) bits.push_back(bit'((vals[j] >> t) & 1));
            exp_coef[j] = (l == 12 && vals[j] >= Q) ? vals[j] - Q : vals[j];
        end
        for (int b = 0; b * IN_W < bits.size(); b++) begin
            w = '0;
            for (int i = 0; i < IN_W; i++) w[i] = bits[b * IN_W + i];
            beats.push_back(w);
        end
    endtask

    task automatic randomVals(input int l);
        for (int j = 0; j < N; j++) vals[j] = int'($urandom_range((1 << l) - 1));
    endtask

    task automatic applyStimulus(input int gap_pct);
        int b = 0;
        int guard = 0;
        while (b < beats.size() && guard < 4000) begin
            @(negedge i_clk);
            guard++;
            if (abort_flag) break;
            if (int'($urandom_range(99)) < gap_pct) begin
                i_ibytes_valid = 1'b0;
                i_ibytes = {$urandom, $urandom};
            end else begin
                i_ibytes_valid = 1'b1;
                i_ibytes = beats[b];
                if (o_ibytes_ready) b++;
            end
        end
        if (abort_flag) begin
            i_ibytes_valid = 1'b0;
        end else begin
            checkValue("in_beats", 64'(b), 64'(beats.size()));
            @(negedge i_clk);
            i_ibytes_valid = 1'b0;
            checkValue("ready_after_last", 64'(o_ibytes_ready), 64'(0));
        end
    endtask

    // ready_mode 0: always ready; 1: random; 2: random with a 20-cycle stall window.
    task automatic checkOutput(input int ready_mode, input int stop_after, input bit tput);
        int ob = 0;
        int guard = 0;
        int first_cyc = -1;
        int last_cyc = 0;
        bit r;
        bit holding = 1'b0;
        logic [LANES*COEF_W-1:0] held = '0;
        logic [LANES*COEF_W-1:0] expv;
        while (ob < stop_after && guard < 4000) begin
            @(negedge i_clk);
            guard++;
            if (holding) begin
                checkValue("stall_valid", 64'(o_coeffs_valid), 64'(1));
                checkValue("stall_hold", 64'(o_coeffs), 64'(held));
            end
            case (ready_mode)
                0: r = 1'b1;
                1: r = ($urandom_range(3) != 0);
                default: r = (guard >= 30 && guard < 50) ? 1'b0 : ($urandom_range(3) != 0);
            endcase
            i_coeffs_ready = r;
            if (ready_mode == 2 && guard == 49)
                checkValue("ready_full", 64'(o_ibytes_ready), 64'(0));
            holding = o_coeffs_valid && !r;
            held = o_coeffs;
            if (o_coeffs_valid && r) begin
                for (int m = 0; m < LANES; m++)
                    expv[m*COEF_W +: COEF_W] = COEF_W'(exp_coef[ob * LANES + m]);
                checkValue($sformatf("beat%0d", ob), 64'(o_coeffs), 64'(expv));
                if (first_cyc < 0) first_cyc = guard;
                last_cyc = guard;
                ob++;
            end
        end
        checkValue("out_beats", 64'(ob), 64'(stop_after));
        if (stop_after == OUT_BEATS) begin
            @(negedge i_clk);
            checkValue("done_pulse", 64'(o_done), 64'(1));
            @(negedge i_clk);
            checkValue("done_clear", 64'(o_done), 64'(0));
            checkValue("no_extra_valid", 64'(o_coeffs_valid), 64'(0));
            if (tput) checkValue("throughput", 64'(last_cyc - first_cyc), 64'(OUT_BEATS - 1));
        end else begin
            abort_flag = 1'b1;
            i_coeffs_ready = 1'b0;
        end
    endtask

    task automatic runPoly(input int l, input int gap_pct, input int ready_mode,
                           input int stop_after, input bit tput);
        int d0 = done_pulses;
        buildStream(l);
        abort_flag = 1'b0;
        @(negedge i_clk);
        i_start = 1'b1;
        i_l = 4'(l);
        @(negedge i_clk);
        i_start = 1'b0;
        checkValue("start_no_err", 64'(o_err), 64'(0));
        fork
            applyStimulus(gap_pct);
            checkOutput(ready_mode, stop_after, tput);
        join
        if (stop_after == OUT_BEATS) begin
            repeat (3) @(negedge i_clk);
            checkValue("done_count", 64'(done_pulses - d0), 64'(1));
        end
    endtask

    initial begin
        int d0;
        $display("[TB] start");
        repeat (3) @(negedge i_clk);
        checkValue("rst_coeffs", 64'(o_coeffs), 64'(0));
        checkValue("rst_valid", 64'(o_coeffs_valid), 64'(0));
        checkValue("rst_ready", 64'(o_ibytes_ready), 64'(0));
        checkValue("rst_done", 64'(o_done), 64'(0));
        checkValue("rst_err", 64'(o_err), 64'(0));
        i_rstn = 1'b1;

        $display("[TB] l=1 all ones, full throughput");
        for (int j = 0; j < N; j++) vals[j] = 1;
        runPoly(1, 0, 0, OUT_BEATS, 1'b1);

        $display("[TB] l=12 ramp");
        for (int j = 0; j < N; j++) vals[j] = j;
        runPoly(12, 0, 0, OUT_BEATS, 1'b0);

        $display("[TB] l=12 modular reduction");
        randomVals(12);
        vals[0] = 'hFFF; vals[1] = 'hD01; vals[2] = 'hD00; vals[3] = 0;
        runPoly(12, 30, 1, OUT_BEATS, 1'b0);

        $display("[TB] l=10 with stall");
        randomVals(10);
        runPoly(10, 20, 2, OUT_BEATS, 1'b0);

        $display("[TB] illegal l=7");
        @(negedge i_clk);
        i_start = 1'b1;
        i_l = 4'd7;
        i_ibytes_valid = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        checkValue("err_pulse", 64'(o_err), 64'(1));
        checkValue("err_ready", 64'(o_ibytes_ready), 64'(0));
        checkValue("err_valid", 64'(o_coeffs_valid), 64'(0));
        @(negedge i_clk);
        i_ibytes_valid = 1'b0;
        checkValue("err_clear", 64'(o_err), 64'(0));
        checkValue("err_idle_ready", 64'(o_ibytes_ready), 64'(0));
        randomVals(5);
        runPoly(5, 10, 1, OUT_BEATS, 1'b0);

        $display("[TB] l=5 aborted by reset");
        d0 = done_pulses;
        randomVals(5);
        runPoly(5, 0, 1, 10, 1'b0);
        #2 i_rstn = 1'b0;
        #1;
        checkValue("abort_coeffs", 64'(o_coeffs), 64'(0));
        checkValue("abort_valid", 64'(o_coeffs_valid), 64'(0));
        checkValue("abort_ready", 64'(o_ibytes_ready), 64'(0));
        checkValue("abort_done", 64'(o_done), 64'(0));
        repeat (2) @(negedge i_clk);
        i_rstn = 1'b1;
        repeat (5) @(negedge i_clk);
        checkValue("abort_no_done", 64'(done_pulses - d0), 64'(0));

        $display("[TB] l=11 after reset");
        randomVals(11);
        runPoly(11, 10, 1, OUT_BEATS, 1'b0);

        $display("[TB] l=4 random");
        randomVals(4);
        runPoly(4, 25, 1, OUT_BEATS, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
